// File: rtl/tmds_encoder_dvi_pkg.sv
// Shared TMDS definitions: symbol/data/counter widths, control tokens,
// stage-1 pipeline payload and the control-token lookup.
package tmds_encoder_dvi_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CTRL_W = 2;
  localparam int unsigned QM_W   = 9;
  localparam int unsigned SYM_W  = 10;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned PC_W   = 4;

  localparam logic [SYM_W-1:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] TMDS_CTRL_11 = 10'b1010101011;

  // Stage-1 register contents: data enable, control bits and transition-minimised word
  typedef struct packed {
    logic              de;
    logic [CTRL_W-1:0] ctrl;
    logic [QM_W-1:0]   qm;
  } s1_t;

  // Control period token for {c1,c0}
  function automatic logic [SYM_W-1:0] ctrl_token(input logic [CTRL_W-1:0] c);
    logic [SYM_W-1:0] tok;
    unique case (c)
      2'b00:   tok = TMDS_CTRL_00;
      2'b01:   tok = TMDS_CTRL_01;
      2'b10:   tok = TMDS_CTRL_10;
      default: tok = TMDS_CTRL_11;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/tmds_encoder_dvi_if.sv
// Pixel-side bus of one TMDS channel.
//   de      : data enable (1 = encode din, 0 = send control token)
//   din     : colour channel data
//   ctrl_in : control bits {c1,c0}
//   tmds    : encoded 10-bit symbol, bit 0 sent first
// master = display pipeline side, slave = encoder side.
interface tmds_encoder_dvi_if;
  import tmds_encoder_dvi_pkg::*;

  logic              de;
  logic [DATA_W-1:0] din;
  logic [CTRL_W-1:0] ctrl_in;
  logic [SYM_W-1:0]  tmds;

  modport master (output de, output din, output ctrl_in, input tmds);
  modport slave  (input de, input din, input ctrl_in, output tmds);
endinterface

// File: rtl/tmds_encoder_dvi_popcount8.sv
// Combinational ones count of an 8-bit word.
//   data_i  : word to count
//   count_o : number of set bits (0..8)
module tmds_encoder_dvi_popcount8
  import tmds_encoder_dvi_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [PC_W-1:0]   count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      count_o = count_o + PC_W'(data_i[i]);
    end
  end

endmodule

// File: rtl/tmds_encoder_dvi.sv
// One DVI TMDS channel encoder: 8-bit data + 2 control bits to 10-bit
// DC-balanced symbols, fixed two-cycle pipeline, running disparity per line.
//   clk_pix   : pixel clock
//   rst_pix_n : asynchronous active-low reset
//   bus       : slave side of tmds_encoder_dvi_if (de, din, ctrl_in in; tmds out)
module tmds_encoder_dvi
  import tmds_encoder_dvi_pkg::*;
(
  input  logic                clk_pix,
  input  logic                rst_pix_n,
  tmds_encoder_dvi_if.slave   bus
);

  s1_t                     s1_d, s1_q;
  logic [QM_W-1:0]         qm_c;
  logic                    use_xnor_c;
  logic [PC_W-1:0]         n1_din, n1_qm;
  logic [SYM_W-1:0]        tmds_d, tmds_q;
  logic signed [CNT_W-1:0] cnt_d, cnt_q;
  logic signed [CNT_W-1:0] disp_c;
  logic signed [CNT_W-1:0] two_q8_c, two_nq8_c;
  logic                    qm8_c;
  logic [DATA_W-1:0]       qm_lo_c;
  logic                    cnt_pos_c, cnt_neg_c, disp_pos_c, disp_neg_c;

  tmds_encoder_dvi_popcount8 u_pc_din (
    .data_i  (bus.din),
    .count_o (n1_din)
  );

  tmds_encoder_dvi_popcount8 u_pc_qm (
    .data_i  (s1_q.qm[DATA_W-1:0]),
    .count_o (n1_qm)
  );

  // Stage 1: choose XOR/XNOR chain to minimise transitions
  always_comb begin
    use_xnor_c = (n1_din > PC_W'(4)) || ((n1_din == PC_W'(4)) && !bus.din[0]);
    qm_c       = '0;
    qm_c[0]    = bus.din[0];
    for (int i = 1; i < int'(DATA_W); i++) begin
      qm_c[i] = use_xnor_c ? ~(qm_c[i-1] ^ bus.din[i]) : (qm_c[i-1] ^ bus.din[i]);
    end
    qm_c[QM_W-1] = ~use_xnor_c;
    s1_d         = '{de: bus.de, ctrl: bus.ctrl_in, qm: qm_c};
  end

  // Stage 2: DC balancing against the running disparity
  always_comb begin
    tmds_d     = TMDS_CTRL_00;
    cnt_d      = '0;
    qm8_c      = s1_q.qm[QM_W-1];
    qm_lo_c    = s1_q.qm[DATA_W-1:0];
    // N1 - N0 = 2*N1 - 8, evaluated modulo 2^CNT_W
    disp_c     = $signed(CNT_W'({n1_qm, 1'b0}) - CNT_W'(8));
    two_q8_c   = qm8_c ? 5'sd2 : 5'sd0;
    two_nq8_c  = qm8_c ? 5'sd0 : 5'sd2;
    cnt_neg_c  = cnt_q[CNT_W-1];
    cnt_pos_c  = !cnt_q[CNT_W-1] && (cnt_q != '0);
    disp_neg_c = disp_c[CNT_W-1];
    disp_pos_c = !disp_c[CNT_W-1] && (disp_c != '0);

    if (!s1_q.de) begin
      tmds_d = ctrl_token(s1_q.ctrl);
      cnt_d  = '0;
    end else if ((cnt_q == '0) || (disp_c == '0)) begin
      tmds_d = {~qm8_c, qm8_c, (qm8_c ? qm_lo_c : ~qm_lo_c)};
      cnt_d  = qm8_c ? (cnt_q + disp_c) : (cnt_q - disp_c);
    end else if ((cnt_pos_c && disp_pos_c) || (cnt_neg_c && disp_neg_c)) begin
      tmds_d = {1'b1, qm8_c, ~qm_lo_c};
      cnt_d  = cnt_q + two_q8_c - disp_c;
    end else begin
      tmds_d = {1'b0, qm8_c, qm_lo_c};
      cnt_d  = cnt_q + disp_c - two_nq8_c;
    end
  end

  // Pipeline and disparity registers; reset presents the 00 control token
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      s1_q   <= '0;
      tmds_q <= TMDS_CTRL_00;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.tmds = tmds_q;

endmodule
